keypad_scanner: RTL and testbench

//  Sequential matrix-keypad controller. Drives one-hot column strobes, samples the row lines,

---
 rtl/keypad_scanner_if.sv | 21 ++
 rtl/keypad_scanner.sv | 197 +++++++++++++++++++
 tb/tb_keypad_scanner.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: valid/ready key channel of keypad_scanner.
// master = scanner side, slave = consumer side.
interface keypad_scanner_if #(
  parameter int CODE_W = 4
);
  logic              key_valid;
  logic [CODE_W-1:0] key_code;
  logic              key_ready;

  modport master (
    output key_valid,
    output key_code,
    input  key_ready
  );

  modport slave (
    input  key_valid,
    input  key_code,
    output key_ready
  );
endinterface

// File: rtl/keypad_scanner.sv
// keypad_scanner: column-strobed matrix keypad scanner with debounce.
// Define KEYPAD_FIFO_EN for a FIFO_DEPTH key FIFO instead of one register.
module keypad_scanner #(
  parameter int ROWS        = 4,
  parameter int COLS        = 3,
  parameter int SCAN_CYCLES = 16,
  parameter int DEBOUNCE    = 4,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ROWS-1:0]   row_in,
  output logic [COLS-1:0]   col_out,
  keypad_scanner_if.master  kif,
  output logic              overflow,
  output logic              busy
);
  localparam int CODE_W = (ROWS*COLS > 1) ? $clog2(ROWS*COLS) : 1;
  localparam int CNT_W  = $clog2(SCAN_CYCLES);
  localparam int DB_W   = $clog2(DEBOUNCE+1);
  localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int COL_W  = (COLS > 1) ? $clog2(COLS) : 1;

  typedef enum logic [1:0] {SCAN, CONFIRM, HELD} state_t;

  state_t            state_q, state_d;
  logic [ROWS-1:0]   row_s1_q, row_s2_q;
  logic [CNT_W-1:0]  dwell_q;
  logic [COL_W-1:0]  col_q, col_d, col_nxt;
  logic [ROW_W-1:0]  row_lat_q, row_lat_d, win_row;
  logic [DB_W-1:0]   db_q, db_d, db_inc;
  logic              sample, hit, db_done, push;
  logic [CODE_W-1:0] code_new;

  assign sample   = (dwell_q == CNT_W'(SCAN_CYCLES-1));
  assign col_nxt  = (col_q == COL_W'(COLS-1)) ? '0 : col_q + 1'b1;
  assign db_inc   = db_q + 1'b1;
  assign db_done  = (db_inc == DB_W'(DEBOUNCE));
  assign code_new = CODE_W'(32'(win_row) * COLS + 32'(col_q));
  assign col_out  = COLS'(1) << col_q;
  assign busy     = (state_q != SCAN);

  // Synchronise raw rows and run the free-running column dwell counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_s1_q <= '0;
      row_s2_q <= '0;
      dwell_q  <= '0;
    end else begin
      row_s1_q <= row_in;
      row_s2_q <= row_s1_q;
      dwell_q  <= sample ? '0 : dwell_q + 1'b1;
    end
  end

  // Lowest-index high row wins.
  always_comb begin
    hit     = 1'b0;
    win_row = '0;
    for (int r = ROWS-1; r >= 0; r--) begin
      if (row_s2_q[r]) begin
        hit     = 1'b1;
        win_row = ROW_W'(r);
      end
    end
  end

  // Scanner state, frozen column, latched row and debounce count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= SCAN;
      col_q     <= '0;
      row_lat_q <= '0;
      db_q      <= '0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_lat_q <= row_lat_d;
      db_q      <= db_d;
    end
  end

  // Next-state decisions, taken only at each dwell sample point.
  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_lat_d = row_lat_q;
    db_d      = db_q;
    push      = 1'b0;
    if (sample) begin
      unique case (state_q)
        SCAN: begin
          if (!hit) begin
            col_d = col_nxt;
          end else if (DEBOUNCE == 1) begin
            push    = 1'b1;
            state_d = HELD;
            db_d    = '0;
          end else begin
            state_d   = CONFIRM;
            row_lat_d = win_row;
            db_d      = DB_W'(1);
          end
        end
        CONFIRM: begin
          if (hit && win_row == row_lat_q) begin
            if (db_done) begin
              push    = 1'b1;
              state_d = HELD;
              db_d    = '0;
            end else begin
              db_d = db_inc;
            end
          end else begin
            state_d = SCAN;
            col_d   = col_nxt;
            db_d    = '0;
          end
        end
        HELD: begin
          if (hit) begin
            db_d = '0;
          end else if (db_done) begin
            state_d = SCAN;
            col_d   = col_nxt;
            db_d    = '0;
          end else begin
            db_d = db_inc;
          end
        end
        default: state_d = SCAN;
      endcase
    end
  end

`ifdef KEYPAD_FIFO_EN
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [CODE_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_q, rd_q;
  logic [PTR_W:0]    cnt_q;
  logic              full, pop, wr;

  assign pop  = kif.key_valid & kif.key_ready;
  assign full = (cnt_q == (PTR_W+1)'(FIFO_DEPTH));
  assign wr   = push & (!full | pop);

  assign kif.key_valid = (cnt_q != '0);
  assign kif.key_code  = mem_q[rd_q];

  // Key FIFO: a push into a full FIFO without a pop is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= push & full & !pop;
      if (wr) begin
        mem_q[wr_q] <= code_new;
        wr_q <= (wr_q == PTR_W'(FIFO_DEPTH-1)) ? '0 : wr_q + 1'b1;
      end
      if (pop) begin
        rd_q <= (rd_q == PTR_W'(FIFO_DEPTH-1)) ? '0 : rd_q + 1'b1;
      end
      if (wr && !pop) cnt_q <= cnt_q + 1'b1;
      else if (pop && !wr) cnt_q <= cnt_q - 1'b1;
    end
  end
`else
  logic [CODE_W-1:0] hold_q;
  logic              vld_q;

  assign kif.key_valid = vld_q;
  assign kif.key_code  = hold_q;

  // Single holding register: an unconsumed key is overwritten.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_q   <= '0;
      vld_q    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      overflow <= push & vld_q & !kif.key_ready;
      if (push) begin
        hold_q <= code_new;
        vld_q  <= 1'b1;
      end else if (vld_q && kif.key_ready) begin
        vld_q <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: keypad matrix model, directed and random presses.
// Expected keys come from a press-level buffer model.
module tb_keypad_scanner;
  localparam int ROWS = 4;
  localparam int COLS = 3;
  localparam int SC   = 16;
  localparam int DB   = 4;
  localparam int FD   = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [ROWS-1:0] row_in;
  logic [COLS-1:0] col_out;
  logic            overflow;
  logic            busy;

  keypad_scanner_if #(.CODE_W(4)) kif ();

  keypad_scanner #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_CYCLES(SC),
    .DEBOUNCE(DB), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk),
    .reset(rst),
    .row_in(row_in),
    .col_out(col_out),
    .kif(kif),
    .overflow(overflow),
    .busy(busy)
  );

  always #5 clk = ~clk;

  logic [ROWS*COLS-1:0] pressed;

  always_comb begin
    row_in = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (pressed[r*COLS+c] && col_out[c]) row_in[r] = 1'b1;
  end

  int cyc = 0;
  int nvalid = 0;
  int novf = 0;
  int pop_log[$];
  int checks = 0;
  int errors = 0;
  int plan[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (kif.key_valid === 1'b1) nvalid++;
    if (kif.key_valid === 1'b1 && kif.key_ready === 1'b1)
      pop_log.push_back(int'(kif.key_code));
    if (overflow === 1'b1) novf++;
  end

  task automatic set_ready(input logic v);
    @(posedge clk);
    #2 kif.key_ready = v;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_fresh_col(input int c, output bit ok);
    int k = 0;
    while (col_out[c] && k < 200) begin @(negedge clk); k++; end
    while (!col_out[c] && k < 200) begin @(negedge clk); k++; end
    ok = col_out[c];
  endtask

  task automatic wait_idle(input int bound, output bit ok);
    int k = 0;
    while (busy && k < bound) begin @(negedge clk); k++; end
    ok = !busy;
  endtask

  task automatic wait_valid(input int bound, output bit ok);
    int k = 0;
    while (!kif.key_valid && k < bound) begin @(negedge clk); k++; end
    ok = kif.key_valid;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    pressed = '0;
    kif.key_ready = 1'b1;
    wait_cyc(3);
    checks++;
    if (col_out !== 3'b001) begin
      errors++; $display("FAIL reset_col got %b exp 001", col_out);
    end
    checks++;
    if (kif.key_valid !== 1'b0 || kif.key_code !== 4'd0) begin
      errors++;
      $display("FAIL reset_key got v=%b c=%0d exp v=0 c=0", kif.key_valid, kif.key_code);
    end
    checks++;
    if (overflow !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_flags got ovf=%b busy=%b exp 0 0", overflow, busy);
    end
    rst = 1'b0;
  endtask

  task automatic test_scan_rotation;
    logic [COLS-1:0] exp_col [3];
    exp_col[0] = 3'b010;
    exp_col[1] = 3'b100;
    exp_col[2] = 3'b001;
    for (int d = 0; d < 3; d++) begin
      for (int i = 1; i <= SC; i++) begin
        @(posedge clk);
        #1;
        if (i == SC - 1) begin
          checks++;
          if (col_out !== exp_col[(d+2)%3]) begin
            errors++;
            $display("FAIL rot_hold%0d got %b exp %b", d, col_out, exp_col[(d+2)%3]);
          end
        end
      end
      checks++;
      if (col_out !== exp_col[d]) begin
        errors++; $display("FAIL rot_step%0d got %b exp %b", d, col_out, exp_col[d]);
      end
    end
    checks++;
    if (nvalid !== 0) begin
      errors++; $display("FAIL rot_novalid got %0d exp 0", nvalid);
    end
  endtask

  task automatic test_single_press;
    bit ok;
    int t0, nv;
    wait_fresh_col(2, ok);
    t0 = cyc;
    nv = nvalid;
    pressed[1*COLS+2] = 1'b1;
    wait_valid(150, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL press_timeout got none exp valid");
    end
    checks++;
    if (cyc - t0 !== DB*SC) begin
      errors++; $display("FAIL press_latency got %0d exp %0d", cyc - t0, DB*SC);
    end
    checks++;
    if (kif.key_code !== 4'd5) begin
      errors++; $display("FAIL press_code got %0d exp 5", kif.key_code);
    end
    wait_cyc(1);
    checks++;
    if (kif.key_valid !== 1'b0) begin
      errors++; $display("FAIL press_pulse got %b exp 0", kif.key_valid);
    end
    wait_cyc(200);
    checks++;
    if (nvalid !== nv + 1) begin
      errors++; $display("FAIL press_norepeat got %0d exp %0d", nvalid - nv, 1);
    end
    pressed = '0;
    wait_idle(120, ok);
    checks++;
    if (!ok || nvalid !== nv + 1) begin
      errors++; $display("FAIL press_release got busy=%b n=%0d exp 0 1", busy, nvalid - nv);
    end
  endtask

  task automatic test_bounce;
    bit ok;
    int nv;
    nv = nvalid;
    wait_fresh_col(0, ok);
    pressed[0] = 1'b1;
    wait_cyc(20);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL bounce_confirm got busy=%b exp 1", busy);
    end
    wait_cyc(20);
    pressed = '0;
    wait_cyc(10);
    checks++;
    if (busy !== 1'b0 || col_out !== 3'b010) begin
      errors++; $display("FAIL bounce_scan got busy=%b col=%b exp 0 010", busy, col_out);
    end
    wait_cyc(40);
    checks++;
    if (nvalid !== nv) begin
      errors++; $display("FAIL bounce_nokey got %0d exp 0", nvalid - nv);
    end
  endtask

  task automatic test_priority;
    bit ok;
    pressed[3*COLS+0] = 1'b1;
    pressed[1*COLS+0] = 1'b1;
    wait_valid(200, ok);
    checks++;
    if (!ok || kif.key_code !== 4'd3) begin
      errors++; $display("FAIL priority got v=%b c=%0d exp 1 3", ok, kif.key_code);
    end
    pressed = '0;
    wait_idle(150, ok);
  endtask

  task automatic test_backpressure(input string name);
    int exp_q[$];
    int exp_ovf, ovf0, base, code;
    bit ok;
    exp_ovf = 0;
    set_ready(1'b0);
    ovf0 = novf;
    base = pop_log.size();
    foreach (plan[i]) begin
      code = plan[i];
      pressed[code] = 1'b1;
      wait_cyc(160);
      pressed = '0;
      wait_idle(150, ok);
      checks++;
      if (!ok) begin
        errors++; $display("FAIL %s_idle%0d got busy=1 exp 0", name, i);
      end
`ifdef KEYPAD_FIFO_EN
      if (exp_q.size() < FD) exp_q.push_back(code);
      else exp_ovf++;
`else
      if (exp_q.size() == 1) begin
        exp_ovf++;
        exp_q[0] = code;
      end else begin
        exp_q.push_back(code);
      end
`endif
    end
    checks++;
    if (novf - ovf0 !== exp_ovf) begin
      errors++; $display("FAIL %s_ovf got %0d exp %0d", name, novf - ovf0, exp_ovf);
    end
    checks++;
    if (kif.key_valid !== 1'b1 || int'(kif.key_code) !== exp_q[0]) begin
      errors++;
      $display("FAIL %s_head got v=%b c=%0d exp 1 %0d", name, kif.key_valid, kif.key_code, exp_q[0]);
    end
    set_ready(1'b1);
    wait_cyc(FD + 4);
    checks++;
    if (pop_log.size() - base !== exp_q.size()) begin
      errors++;
      $display("FAIL %s_npop got %0d exp %0d", name, pop_log.size() - base, exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (pop_log[base+i] !== exp_q[i]) begin
          errors++;
          $display("FAIL %s_pop%0d got %0d exp %0d", name, i, pop_log[base+i], exp_q[i]);
        end
      end
    end
    checks++;
    if (kif.key_valid !== 1'b0) begin
      errors++; $display("FAIL %s_drain got %b exp 0", name, kif.key_valid);
    end
  endtask

  task automatic test_reset_confirm;
    bit ok;
    int nv;
    wait_fresh_col(1, ok);
    pressed[1*COLS+1] = 1'b1;
    wait_cyc(24);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL rstc_confirm got busy=%b exp 1", busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (col_out !== 3'b001 || busy !== 1'b0 || kif.key_valid !== 1'b0) begin
      errors++;
      $display("FAIL rstc_state got col=%b busy=%b v=%b exp 001 0 0", col_out, busy, kif.key_valid);
    end
    pressed = '0;
    wait_cyc(3);
    rst = 1'b0;
    nv = nvalid;
    wait_cyc(150);
    checks++;
    if (nvalid !== nv || busy !== 1'b0) begin
      errors++; $display("FAIL rstc_nokey got n=%0d busy=%b exp 0 0", nvalid - nv, busy);
    end
  endtask

  task automatic test_random_keys;
    bit ok;
    int code, nv;
    for (int i = 0; i < 6; i++) begin
      code = $urandom_range(0, ROWS*COLS-1);
      nv = nvalid;
      pressed[code] = 1'b1;
      wait_valid(200, ok);
      checks++;
      if (!ok || int'(kif.key_code) !== code) begin
        errors++; $display("FAIL rand%0d_code got v=%b c=%0d exp 1 %0d", i, ok, kif.key_code, code);
      end
      wait_cyc($urandom_range(0, 80));
      pressed = '0;
      wait_idle(150, ok);
      checks++;
      if (!ok || nvalid !== nv + 1) begin
        errors++; $display("FAIL rand%0d_once got busy=%b n=%0d exp 0 1", i, busy, nvalid - nv);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_scan_rotation();
    test_single_press();
    test_bounce();
    test_priority();
    plan = '{4, 7};
`ifdef KEYPAD_FIFO_EN
    plan = '{4, 7, 0, 11, 6};
`endif
    test_backpressure("bp_dir");
    plan.delete();
    for (int i = 0; i < $urandom_range(2, 6); i++)
      plan.push_back($urandom_range(0, ROWS*COLS-1));
    test_backpressure("bp_rnd");
    test_reset_confirm();
    test_random_keys();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
